// File: rtl/spi_reg_pkg.sv
// Shared defaults, counter address map and access-type encoding for the SPI register bank.
package spi_reg_pkg;

    localparam int                 DSZ_DEF          = 8;
    localparam int                 ADDR_W_DEF       = 7;
    localparam logic [ADDR_W_DEF-1:0] ERR_CNT_ADDR_DEF = 7'h7C;
    localparam logic [ADDR_W_DEF-1:0] RD_CNT_ADDR_DEF  = 7'h7E;
    localparam logic [ADDR_W_DEF-1:0] WR_CNT_ADDR_DEF  = 7'h7F;

    // Encoded as {re_en, we_en}.
    typedef enum logic [1:0] {
        ACC_NONE = 2'b00,
        ACC_WR   = 2'b01,
        ACC_RD   = 2'b10,
        ACC_RDWR = 2'b11
    } acc_e;

endpackage

// File: rtl/spi_reg_bank_sync_pulse.sv
// Synchronises an asynchronous strobe and emits a single-cycle enable on its rising edge.
module sync_pulse #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_strobe,
    output logic o_en
);

    logic [STAGES-1:0] r_sync;
    logic              r_hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_strobe};
            r_hist <= r_sync[STAGES-1];
        end
    end

    assign o_en = r_sync[STAGES-1] & ~r_hist;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI-facing register bank: general R/W registers plus read/write/error counters.
// Define SPI_REG_BANK_CNT_SAT_EN to make the counters saturate instead of wrapping.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int                 DSZ          = DSZ_DEF,
    parameter int                 ADDR_W       = ADDR_W_DEF,
    parameter int                 NUM_REGS     = 4,
    parameter logic [ADDR_W-1:0]  BASE_ADDR    = 7'h70,
    parameter logic [ADDR_W-1:0]  ERR_CNT_ADDR = ERR_CNT_ADDR_DEF,
    parameter logic [ADDR_W-1:0]  RD_CNT_ADDR  = RD_CNT_ADDR_DEF,
    parameter logic [ADDR_W-1:0]  WR_CNT_ADDR  = WR_CNT_ADDR_DEF,
    parameter int                 SYNC_STAGES  = 2,
    parameter logic [DSZ-1:0]     RESET_VAL    = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    spi_re,
    input  logic                    spi_we,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DSZ-1:0]          wdat,
    output logic [DSZ-1:0]          rdat,
    output logic                    rd_done,
    output logic [NUM_REGS*DSZ-1:0] regs_flat,
    output logic [DSZ-1:0]          read_count,
    output logic [DSZ-1:0]          write_count,
    output logic [DSZ-1:0]          err_count
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    function automatic bit f_in_regs(input logic [ADDR_W-1:0] a);
        return (int'(a) >= int'(BASE_ADDR)) && (int'(a) < int'(BASE_ADDR) + NUM_REGS);
    endfunction

    generate
        if (NUM_REGS < 1 || NUM_REGS > 16) begin : g_bad_num_regs
            $error("spi_reg_bank: NUM_REGS must be 1..16");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("spi_reg_bank: SYNC_STAGES must be >= 2");
        end
        if (int'(BASE_ADDR) + NUM_REGS > (1 << ADDR_W)) begin : g_bad_range
            $error("spi_reg_bank: general registers exceed the address space");
        end
        if (f_in_regs(ERR_CNT_ADDR) || f_in_regs(RD_CNT_ADDR) || f_in_regs(WR_CNT_ADDR)) begin : g_overlap
            $error("spi_reg_bank: counter address overlaps the general registers");
        end
    endgenerate

    function automatic logic [DSZ-1:0] f_inc(input logic [DSZ-1:0] v, input logic [1:0] n);
        logic [DSZ+1:0] s;
        s = {2'b00, v} + {{DSZ{1'b0}}, n};
`ifdef SPI_REG_BANK_CNT_SAT_EN
        if (s[DSZ+1:DSZ] != 2'b00) return '1;
`endif
        return s[DSZ-1:0];
    endfunction

    logic                          w_re_en, w_we_en;
    acc_e                          w_acc;
    logic [ADDR_W:0]               w_off;
    logic [IDX_W-1:0]              w_idx;
    logic                          w_reg_hit, w_rd_mapped;
    logic [DSZ-1:0]                w_rd_val;
    logic                          w_rd_inc, w_wr_inc;
    logic [1:0]                    w_err_inc;

    logic [NUM_REGS-1:0][DSZ-1:0]  r_regs;
    logic [DSZ-1:0]                r_rdat, r_rd_cnt, r_wr_cnt, r_err_cnt;
    logic                          r_rd_done;

    sync_pulse #(.STAGES(SYNC_STAGES)) u_re_sync (
        .clk      (clk),
        .reset    (reset),
        .i_strobe (spi_re),
        .o_en     (w_re_en)
    );

    sync_pulse #(.STAGES(SYNC_STAGES)) u_we_sync (
        .clk      (clk),
        .reset    (reset),
        .i_strobe (spi_we),
        .o_en     (w_we_en)
    );

    assign w_acc = acc_e'({w_re_en, w_we_en});

    // Below BASE_ADDR the offset wraps to a huge value, so one compare covers both bounds.
    assign w_off       = {1'b0, addr} - {1'b0, BASE_ADDR};
    assign w_reg_hit   = (w_off < (ADDR_W+1)'(NUM_REGS));
    assign w_idx       = w_off[IDX_W-1:0];
    assign w_rd_mapped = w_reg_hit || (addr == RD_CNT_ADDR) ||
                         (addr == WR_CNT_ADDR) || (addr == ERR_CNT_ADDR);

    always_comb begin
        w_rd_val = '0;
        if (w_reg_hit)                 w_rd_val = r_regs[w_idx];
        else if (addr == RD_CNT_ADDR)  w_rd_val = r_rd_cnt;
        else if (addr == WR_CNT_ADDR)  w_rd_val = r_wr_cnt;
        else if (addr == ERR_CNT_ADDR) w_rd_val = r_err_cnt;
    end

    always_comb begin
        w_rd_inc  = 1'b0;
        w_wr_inc  = 1'b0;
        w_err_inc = 2'd0;
        case (w_acc)
            ACC_RD: begin
                w_rd_inc  = 1'b1;
                w_err_inc = {1'b0, ~w_rd_mapped};
            end
            ACC_WR: begin
                w_wr_inc  = w_reg_hit;
                w_err_inc = {1'b0, ~w_reg_hit};
            end
            ACC_RDWR: begin
                w_rd_inc  = 1'b1;
                w_wr_inc  = w_reg_hit;
                w_err_inc = {1'b0, ~w_rd_mapped} + {1'b0, ~w_reg_hit};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_regs    <= {NUM_REGS{RESET_VAL}};
            r_rdat    <= '0;
            r_rd_done <= 1'b0;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_err_cnt <= '0;
        end else begin
            r_rd_done <= w_re_en;
            if (w_re_en)
                r_rdat <= w_rd_val;
            if (w_we_en && w_reg_hit)
                r_regs[w_idx] <= wdat;
            r_rd_cnt  <= f_inc(r_rd_cnt, {1'b0, w_rd_inc});
            r_wr_cnt  <= f_inc(r_wr_cnt, {1'b0, w_wr_inc});
            r_err_cnt <= f_inc(r_err_cnt, w_err_inc);
        end
    end

    assign rdat        = r_rdat;
    assign rd_done     = r_rd_done;
    assign regs_flat   = r_regs;
    assign read_count  = r_rd_cnt;
    assign write_count = r_wr_cnt;
    assign err_count   = r_err_cnt;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: reads queue expected rdat and edge number, a monitor checks them.
module tb_spi_reg_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_re = 1'b0;
    logic        spi_we = 1'b0;
    logic [6:0]  addr = '0;
    logic [7:0]  wdat = '0;
    logic [7:0]  rdat;
    logic        rd_done;
    logic [31:0] regs_flat;
    logic [7:0]  read_count, write_count, err_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t sb_q[$];

    spi_reg_bank dut (
        .clk         (clk),
        .reset       (reset),
        .spi_re      (spi_re),
        .spi_we      (spi_we),
        .addr        (addr),
        .wdat        (wdat),
        .rdat        (rdat),
        .rd_done     (rd_done),
        .regs_flat   (regs_flat),
        .read_count  (read_count),
        .write_count (write_count),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every rd_done pulse must match the oldest queued read.
    always @(negedge clk) begin
        if (!reset && rd_done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_done_unexpected: got pulse with rdat 0x%0h expected no pulse", rdat);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rdat", int'(rdat), int'(e.data));
                chk("rd_latency", cyc, e.cyc);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; spi_re = 1'b0; spi_we = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd(input logic [6:0] a, input logic [7:0] exp, input int hold);
        @(negedge clk);
        addr = a; spi_re = 1'b1;
        sb_q.push_back('{exp, cyc + 3});
        repeat (hold) @(negedge clk);
        spi_re = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wdat = d; spi_we = 1'b1;
        repeat (3) @(negedge clk);
        spi_we = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic rdwr(input logic [6:0] a, input logic [7:0] d, input logic [7:0] exp);
        @(negedge clk);
        addr = a; wdat = d; spi_re = 1'b1; spi_we = 1'b1;
        sb_q.push_back('{exp, cyc + 3});
        repeat (3) @(negedge clk);
        spi_re = 1'b0; spi_we = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        do_reset();
        chk("reset_rdat", int'(rdat), 0);
        chk("reset_rd_done", int'(rd_done), 0);
        chk("reset_regs", int'(regs_flat), 0);
        chk("reset_rd_cnt", int'(read_count), 0);
        chk("reset_wr_cnt", int'(write_count), 0);
        chk("reset_err_cnt", int'(err_count), 0);

        // Basic write then read-back.
        wr(7'h70, 8'hA5);
        chk("reg0_after_wr", int'(regs_flat[7:0]), 8'hA5);
        rd(7'h70, 8'hA5, 3);
        chk("t1_wr_cnt", int'(write_count), 1);
        chk("t1_rd_cnt", int'(read_count), 1);

        // Long strobe yields one read; read counter returns pre-increment value.
        do_reset();
        rd(7'h7E, 8'h00, 20);
        chk("t2_rd_cnt", int'(read_count), 1);
        rd(7'h7E, 8'h01, 3);

        // Unmapped read and write to a read-only counter.
        do_reset();
        rd(7'h10, 8'h00, 3);
        wr(7'h7E, 8'hFF);
        chk("t3_err_cnt", int'(err_count), 2);
        chk("t3_rd_cnt", int'(read_count), 1);
        chk("t3_wr_cnt", int'(write_count), 0);
        rd(7'h7E, 8'h01, 3);
        rd(7'h7C, 8'h02, 3);

        // Simultaneous read and write of the same register.
        do_reset();
        wr(7'h71, 8'h11);
        rdwr(7'h71, 8'h22, 8'h11);
        chk("t4_reg1", int'(regs_flat[15:8]), 8'h22);
        chk("t4_rd_cnt", int'(read_count), 1);
        chk("t4_wr_cnt", int'(write_count), 2);
        rdwr(7'h10, 8'h33, 8'h00);
        chk("t4_err_dual", int'(err_count), 2);
        rd(7'h7F, 8'h02, 3);

        // Reset interrupting a write, then a strobe held through release.
        do_reset();
        wr(7'h71, 8'h22);
        rd(7'h71, 8'h22, 3);
        @(negedge clk);
        addr = 7'h72; wdat = 8'h5A; spi_we = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rdat", int'(rdat), 0);
        chk("rst_rd_done", int'(rd_done), 0);
        chk("rst_regs", int'(regs_flat), 0);
        chk("rst_wr_cnt", int'(write_count), 0);
        chk("rst_rd_cnt", int'(read_count), 0);
        reset = 1'b0;
        r = cyc;
        repeat (2) @(negedge clk);
        chk("rel_edge2_reg2", int'(regs_flat[23:16]), 0);
        @(negedge clk);
        chk("rel_edge_count", cyc - r, 3);
        chk("rel_edge3_reg2", int'(regs_flat[23:16]), 8'h5A);
        repeat (6) @(negedge clk);
        spi_we = 1'b0;
        repeat (4) @(negedge clk);
        chk("rel_wr_cnt", int'(write_count), 1);
        chk("rel_err_cnt", int'(err_count), 0);

        // 257 unmapped reads: wrap or saturate.
        do_reset();
        for (int i = 0; i < 257; i++) rd(7'h10, 8'h00, 1);
`ifdef SPI_REG_BANK_CNT_SAT_EN
        chk("wrap_rd_cnt", int'(read_count), 8'hFF);
        chk("wrap_err_cnt", int'(err_count), 8'hFF);
`else
        chk("wrap_rd_cnt", int'(read_count), 8'h01);
        chk("wrap_err_cnt", int'(err_count), 8'h01);
`endif

        repeat (5) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Parametrised SPI-facing register bank behind spi_slave.
- Syncs the asynchronous SPI read/write strobes into the clk domain and turns each strobe into a single-cycle enable.
- Serves NUM_REGS general read/write registers plus read, write and error counters at fixed addresses.
- Exposes all registers and counters to fabric logic as outputs.

Parameters:
- DSZ, 8, data width of registers, counters, wdat and rdat
- ADDR_W, 7, SPI address width
- NUM_REGS, 4, number of general registers (1..16)
- BASE_ADDR, 7'h70, address of general register 0; register i is at BASE_ADDR+i
- ERR_CNT_ADDR, 7'h7C, address of the bad-address counter
- RD_CNT_ADDR, 7'h7E, address of the read counter
- WR_CNT_ADDR, 7'h7F, address of the write counter
- SYNC_STAGES, 2, synchroniser depth for spi_re/spi_we (>=2)
- RESET_VAL, 0, reset value of every general register

Ports:
- clk  in  1  system clock; all logic is on its rising edge
- reset  in  1  synchronous, active-high reset
- spi_re  in  1  read strobe from spi_slave; asynchronous to clk
- spi_we  in  1  write strobe from spi_slave; asynchronous to clk
- addr  in  ADDR_W  register address; stable while a strobe is high
- wdat  in  DSZ  write data; stable while spi_we is high
- rdat  out  DSZ  read data returned to spi_slave
- rd_done  out  1  one-cycle pulse in the cycle after rdat updates
- regs_flat  out  NUM_REGS*DSZ  general registers; register i is at bits [i*DSZ +: DSZ]
- read_count  out  DSZ  number of accepted reads
- write_count  out  DSZ  number of accepted writes
- err_count  out  DSZ  number of accesses to unmapped addresses

Behaviour:
- Strobe conditioning:
  - spi_re and spi_we each pass through a SYNC_STAGES flop chain.
  - re_en = last stage & ~history flop. we_en is formed the same way.
  - Each strobe yields exactly one enable cycle, however long the strobe is held.
- Latency: the enable is high in the cycle after the (SYNC_STAGES)th edge that sees the strobe high, and the action happens at the next edge. With SYNC_STAGES=2, rdat or the register changes on edge 3, counting the first sampling edge as 1.
- Write (we_en), by addr:
  - In BASE_ADDR..BASE_ADDR+NUM_REGS-1: the register takes wdat and write_count increments.
  - Any other address, including the counter addresses: no state change except err_count increments. Counters are read-only.
- Read (re_en), by addr:
  - rdat takes the general register, read_count, write_count or err_count value for that address.
  - Unmapped address: rdat takes 0 and err_count increments.
  - read_count increments on every read, mapped or not.
  - Reading RD_CNT_ADDR returns the value before the increment.
  - rd_done is registered and high for one cycle after each rdat update.
- Simultaneous re_en and we_en on the same cycle:
  - Both are processed.
  - A read of the register being written returns the old value.
  - The counters apply both increments in that cycle; err_count may increase by 2.
- Counters wrap modulo 2^DSZ by default.
- Reset has priority over all activity:
  - General registers go to RESET_VAL. rdat, all counters, rd_done, sync chains and history flops go to 0.
  - A strobe interrupted by reset is discarded.
  - A strobe held high through reset release produces exactly one enable, SYNC_STAGES+1 cycles after release.
- Address map overlap between the general registers and counter addresses is a configuration error: an elaboration-time check must fail the build.

Optional Feature:
- Macro: SPI_REG_BANK_CNT_SAT_EN.
- Defined: read_count, write_count and err_count saturate at all-ones and hold there until reset.
- Undefined: the counters wrap to 0 after all-ones.

Decomposition:
- Package spi_reg_pkg: default DSZ/ADDR_W, the ERR/RD/WR counter address constants, and an access-type enum (ACC_NONE, ACC_RD, ACC_WR, ACC_RDWR).
- Sub-module sync_pulse: SYNC_STAGES chain, history flop and rising-edge enable, with synchronous reset. Instantiated once for spi_re and once for spi_we.

Test Plan:
- Write 0xA5 to 0x70, then read 0x70 -> rdat=0xA5 on edge 3 after spi_re rises; write_count=1, read_count=1; rd_done pulses once.
- Hold spi_re high for 20 cycles at addr 0x7E -> exactly one enable; rdat=0x00; read_count=1. A second read of 0x7E returns 0x01.
- Read addr 0x10, then write 0x7E -> rdat=0; err_count=2; read_count=1; write_count=0; 0x7E still reads 0x01.
- Strobes rise together: spi_re and spi_we at addr 0x71, reg=0x11, wdat=0x22 -> rdat=0x11; reg becomes 0x22; both counters increment.
- Assert reset two cycles after spi_we rises -> no write takes effect; all outputs 0 and registers = RESET_VAL. With spi_we held high through release -> exactly one write, 3 cycles after release.
- 257 reads: without SPI_REG_BANK_CNT_SAT_EN read_count=0x01; with it, read_count=0xFF.
